// File: rtl/alu_mac_sequencer.sv
// Neuron evaluation sequencer: streams (x, w) pairs through a shared external
// combinational ALU to form sum(x_i * w_i) +/- bias, then hands the result out.
module alu_mac_sequencer #(
    parameter int unsigned N_TERMS = 4,
    parameter int unsigned DW      = 16,
    parameter int unsigned CW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] bias,
    input  logic          bias_sub,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_x,
    input  logic [DW-1:0] in_w,
    output logic          alu_enable,
    output logic [1:0]    alu_op_sel,
    output logic [DW-1:0] alu_op_a,
    output logic [DW-1:0] alu_op_b,
    input  logic [DW-1:0] alu_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          busy
);

    localparam logic [1:0]    OP_ADD    = 2'b00;
    localparam logic [1:0]    OP_SUB    = 2'b01;
    localparam logic [1:0]    OP_MUL    = 2'b10;
    localparam logic [CW-1:0] LAST_TERM = CW'(N_TERMS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_ACC,
        S_BIAS,
        S_DONE
    } state_t;

    state_t        state;
    logic [DW-1:0] acc;
    logic [DW-1:0] prod;
    logic [CW-1:0] cnt;
    logic [DW-1:0] bias_r;
    logic          bsub_r;

    // Sequencer FSM; handshake/status outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            acc       <= '0;
            prod      <= '0;
            cnt       <= '0;
            bias_r    <= '0;
            bsub_r    <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        bias_r   <= bias;
                        bsub_r   <= bias_sub;
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= S_MUL;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_MUL: begin
                    if (in_valid) begin
                        prod     <= alu_result;
                        state    <= S_ACC;
                        in_ready <= 1'b0;
                    end
                end
                S_ACC: begin
                    acc <= alu_result;
                    if (cnt == LAST_TERM) begin
                        state <= S_BIAS;
                    end else begin
                        cnt      <= cnt + CW'(1);
                        state    <= S_MUL;
                        in_ready <= 1'b1;
                    end
                end
                S_BIAS: begin
                    acc       <= alu_result;
                    out_data  <= alu_result;
                    state     <= S_DONE;
                    out_valid <= 1'b1;
                end
                S_DONE: begin
                    // start is deliberately not looked at here: only IDLE honours it.
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // ALU command decode; everything forced to zero whenever the ALU is not in use.
    always_comb begin
        alu_enable = 1'b0;
        alu_op_sel = OP_ADD;
        alu_op_a   = '0;
        alu_op_b   = '0;
        case (state)
            S_MUL: begin
                if (in_valid) begin
                    alu_enable = 1'b1;
                    alu_op_sel = OP_MUL;
                    alu_op_a   = in_x;
                    alu_op_b   = in_w;
                end
            end
            S_ACC: begin
                alu_enable = 1'b1;
                alu_op_sel = OP_ADD;
                alu_op_a   = acc;
                alu_op_b   = prod;
            end
            S_BIAS: begin
                alu_enable = 1'b1;
                alu_op_sel = bsub_r ? OP_SUB : OP_ADD;
                alu_op_a   = acc;
                alu_op_b   = bias_r;
            end
            default: begin
                alu_enable = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_mac_sequencer.sv
// Self-checking bench: two sequencers (4 and 2 terms) each driving a behavioural ALU,
// checked against a sum-of-products reference and an expected ALU command list.
module tb_alu_mac_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, sel, bias_sub, in_valid, out_ready;
    logic [15:0] bias, in_x, in_w;

    logic        start4, start2;
    logic        in_ready4, alu_en4, out_valid4, busy4;
    logic        in_ready2, alu_en2, out_valid2, busy2;
    logic [1:0]  op4, op2;
    logic [15:0] a4, b4, res4, out_data4;
    logic [15:0] a2, b2, res2, out_data2;

    int tests = 0;
    int fails = 0;

    logic [15:0] tx_x[4];
    logic [15:0] tx_w[4];
    int          tx_stall[4];

    function automatic logic [15:0] alu_f(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] m;
        m = 32'(a) * 32'(b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return m[15:0];
            default: return 16'hDEAD;
        endcase
    endfunction

    assign start4 = start & ~sel;
    assign start2 = start & sel;
    assign res4   = alu_f(op4, a4, b4);
    assign res2   = alu_f(op2, a2, b2);

    alu_mac_sequencer #(.N_TERMS(4), .DW(16), .CW(8)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .bias(bias), .bias_sub(bias_sub),
        .in_valid(in_valid), .in_ready(in_ready4), .in_x(in_x), .in_w(in_w),
        .alu_enable(alu_en4), .alu_op_sel(op4), .alu_op_a(a4), .alu_op_b(b4),
        .alu_result(res4), .out_valid(out_valid4), .out_ready(out_ready),
        .out_data(out_data4), .busy(busy4)
    );

    alu_mac_sequencer #(.N_TERMS(2), .DW(16), .CW(8)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .bias(bias), .bias_sub(bias_sub),
        .in_valid(in_valid), .in_ready(in_ready2), .in_x(in_x), .in_w(in_w),
        .alu_enable(alu_en2), .alu_op_sel(op2), .alu_op_a(a2), .alu_op_b(b2),
        .alu_result(res2), .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .busy(busy2)
    );

    // Selected DUT (m) and the other, idle one (o)
    logic        in_ready_m, alu_en_m, out_valid_m, busy_m;
    logic [1:0]  op_m;
    logic [15:0] a_m, b_m, out_data_m;
    logic [3:0]  other_flags;
    assign in_ready_m  = sel ? in_ready2  : in_ready4;
    assign alu_en_m    = sel ? alu_en2    : alu_en4;
    assign out_valid_m = sel ? out_valid2 : out_valid4;
    assign busy_m      = sel ? busy2      : busy4;
    assign op_m        = sel ? op2        : op4;
    assign a_m         = sel ? a2         : a4;
    assign b_m         = sel ? b2         : b4;
    assign out_data_m  = sel ? out_data2  : out_data4;
    assign other_flags = sel ? {busy4, in_ready4, out_valid4, alu_en4}
                             : {busy2, in_ready2, out_valid2, alu_en2};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ":dut4"}, {in_ready4, out_valid4, busy4, alu_en4, op4, a4, b4, out_data4}, 64'd0);
        check({tag, ":dut2"}, {in_ready2, out_valid2, busy2, alu_en2, op2, a2, b2, out_data2}, 64'd0);
    endtask

    // One full neuron on the selected DUT using tx_* pairs and stall counts.
    task automatic run_neuron(input bit s, input logic [15:0] b, input bit bsub,
                              input int hold, input bit poke, input string tag);
        int          n, lat, cyc, idx, stall, vcyc, dcnt;
        bit          hs, finished;
        logic [15:0] acc, p, expv, hold_data;
        logic [33:0] expq[$];
        logic [33:0] gotq[$];

        n   = s ? 2 : 4;
        acc = 16'h0;
        lat = 2 * n + 2;
        for (int i = 0; i < n; i++) begin
            p = alu_f(2'b10, tx_x[i], tx_w[i]);
            expq.push_back({2'b10, tx_x[i], tx_w[i]});
            expq.push_back({2'b00, acc, p});
            acc = acc + p;
            lat += tx_stall[i];
        end
        expq.push_back({bsub ? 2'b01 : 2'b00, acc, b});
        expv = bsub ? acc - b : acc + b;

        @(negedge clk);
        sel = s; bias = b; bias_sub = bsub; start = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0;
        #1 check({tag, ":idle_before"}, {busy_m, in_ready_m, out_valid_m}, 64'd0);

        cyc = 0; idx = 0; stall = tx_stall[0]; vcyc = -1; dcnt = 0;
        hs = 1'b0; finished = 1'b0; hold_data = 16'h0;
        while (!finished && cyc < 300) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            bias = 16'($urandom);
            bias_sub = 1'($urandom);
            if (hs) begin
                idx++;
                if (idx < n) stall = tx_stall[idx];
            end
            if (idx < n && in_ready_m && stall > 0) begin
                stall--;
                in_valid = 1'b0;
                in_x = 16'($urandom); in_w = 16'($urandom);
            end else if (idx < n) begin
                in_valid = 1'b1;
                in_x = tx_x[idx]; in_w = tx_w[idx];
            end else begin
                in_valid = 1'b0;
                in_x = 16'($urandom); in_w = 16'($urandom);
            end
            if (out_valid_m) begin
                dcnt++;
                if (vcyc < 0) begin
                    vcyc = cyc;
                    hold_data = out_data_m;
                end else begin
                    check({tag, ":done_hold"}, {busy_m, out_data_m}, {1'b1, hold_data});
                end
                if (dcnt <= hold) begin
                    out_ready = 1'b0;
                    if (poke && dcnt == 2) start = 1'b1;
                end else begin
                    out_ready = 1'b1;
                    start = poke;
                    finished = 1'b1;
                end
            end else begin
                out_ready = 1'($urandom);
            end
            #1;
            if (alu_en_m) gotq.push_back({op_m, a_m, b_m});
            else check({tag, ":alu_idle_zero"}, {op_m, a_m, b_m}, 64'd0);
            check({tag, ":other_quiet"}, other_flags, 64'd0);
            hs = in_valid && in_ready_m;
        end

        check({tag, ":finished"}, finished, 1);
        check({tag, ":latency"}, vcyc, lat);
        check({tag, ":out_data"}, hold_data, expv);
        check({tag, ":alu_op_count"}, gotq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < gotq.size(); i++)
            check($sformatf("%s:alu_cmd%0d", tag, i), gotq[i], expq[i]);

        @(negedge clk);
        start = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        #1 check({tag, ":back_idle"}, {busy_m, in_ready_m, out_valid_m, out_data_m}, {3'b000, expv});
        if (poke) begin
            @(negedge clk);
            #1 check({tag, ":start_dropped"}, {busy_m, in_ready_m}, 64'd0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sel = 1'b0; bias_sub = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; bias = 16'h0; in_x = 16'h0; in_w = 16'h0;
        repeat (3) @(negedge clk);
        #1 check_reset_state("reset");
        rst = 1'b0;

        // Zero-product neuron: result is just the bias
        for (int i = 0; i < 4; i++) begin
            tx_x[i] = 16'h0; tx_w[i] = 16'($urandom); tx_stall[i] = 0;
        end
        run_neuron(1'b0, 16'h0123, 1'b0, 0, 1'b0, "zero_prod");

        // Reset in MUL with two terms already accumulated
        @(negedge clk);
        sel = 1'b0; start = 1'b1; in_valid = 1'b1;
        in_x = 16'h0011; in_w = 16'h0022;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1 check("midrst:pre_in_ready", in_ready4, 1);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1 check_reset_state($sformatf("midrst%0d", c));
        end
        rst = 1'b0; in_valid = 1'b0;

        // Bias subtract wrapping below zero
        for (int i = 0; i < 4; i++) begin
            tx_x[i] = (i == 0) ? 16'h0001 : 16'h0000;
            tx_w[i] = (i == 0) ? 16'h0001 : 16'($urandom);
            tx_stall[i] = 0;
        end
        run_neuron(1'b0, 16'h0003, 1'b1, 0, 1'b0, "bias_sub_wrap");

        // Two stall cycles before pair 2
        for (int i = 0; i < 4; i++) begin
            tx_x[i] = 16'($urandom); tx_w[i] = 16'($urandom);
            tx_stall[i] = (i == 2) ? 2 : 0;
        end
        run_neuron(1'b0, 16'($urandom), 1'b0, 0, 1'b0, "stall");

        // Output backpressure with start pulsed in DONE
        for (int i = 0; i < 4; i++) begin
            tx_x[i] = 16'($urandom); tx_w[i] = 16'($urandom); tx_stall[i] = 0;
        end
        run_neuron(1'b0, 16'($urandom), 1'b1, 5, 1'b1, "backpressure");

        // Two-term accumulation wrapping past 0x7FFF
        tx_x[0] = 16'h7FFF; tx_w[0] = 16'h0001;
        tx_x[1] = 16'h0002; tx_w[1] = 16'h0001;
        tx_stall[0] = 0; tx_stall[1] = 0;
        run_neuron(1'b1, 16'h0000, 1'b0, 0, 1'b0, "acc_wrap");

        // Randomised neurons on both instances
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++) begin
                tx_x[i] = 16'($urandom); tx_w[i] = 16'($urandom);
                tx_stall[i] = int'($urandom_range(0, 2));
            end
            run_neuron(1'(k % 2), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                       1'($urandom), $sformatf("rand%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
